// File: rtl/matraptor_row_merge_pe_if.sv
// Stream interface for the MatRaptor row-merge PE: partial-product input stream
// and merged CSR-ordered output stream.
interface matraptor_row_merge_pe_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_val;
    logic [IDX_W-1:0]  in_row;
    logic [IDX_W-1:0]  in_col;
    logic              in_seg_last;
    logic              in_row_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_val;
    logic [IDX_W-1:0]  out_row;
    logic [IDX_W-1:0]  out_col;
    logic              out_row_last;

    modport slave (
        input  in_valid, in_val, in_row, in_col, in_seg_last, in_row_last, out_ready,
        output in_ready, out_valid, out_val, out_row, out_col, out_row_last
    );

    modport master (
        output in_valid, in_val, in_row, in_col, in_seg_last, in_row_last, out_ready,
        input  in_ready, out_valid, out_val, out_row, out_col, out_row_last
    );
endinterface

// File: rtl/matraptor_row_merge_pe.sv
// MatRaptor row-merge PE: fills one sorted queue per input segment, then k-way
// merges the queues in column order, summing duplicate columns into one entry.
module matraptor_row_merge_pe #(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 16,
    parameter int NQ      = 4,
    parameter int Q_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matraptor_row_merge_pe_if.slave bus,
    output logic                    busy_o,
    output logic                    err_overflow_o
);
    localparam int PTR_W = $clog2(Q_DEPTH) + 1;
    localparam int AW    = PTR_W - 1;
    localparam int SEG_W = $clog2(NQ + 1);
    localparam int QI_W  = (NQ > 1) ? $clog2(NQ) : 1;

    typedef enum logic {S_FILL = 1'b0, S_MERGE = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_val_q [NQ][Q_DEPTH];
    logic [IDX_W-1:0]  mem_col_q [NQ][Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q  [NQ];
    logic [PTR_W-1:0]  rd_ptr_q  [NQ];
    logic [NQ-1:0]     empty_s, full_s;

    logic [SEG_W-1:0]  seg_idx_q, seg_idx_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic              acc_valid_q, acc_valid_d;
    logic [DATA_W-1:0] acc_val_q, acc_val_d;
    logic [IDX_W-1:0]  acc_col_q, acc_col_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_val_q, out_val_d;
    logic [IDX_W-1:0]  out_row_q, out_row_d;
    logic [IDX_W-1:0]  out_col_q, out_col_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;

    logic              accept_s, wr_en_s, pop_s, slot_free_s, seg_full_s;
    logic              head_found_s, take_s;
    logic [QI_W-1:0]   head_idx_s;
    logic [IDX_W-1:0]  head_col_s;
    logic [DATA_W-1:0] head_val_s;

    // Queue status from wrap-bit pointers
    always_comb begin
        empty_s    = '0;
        full_s     = '0;
        seg_full_s = 1'b0;
        for (int k = 0; k < NQ; k++) begin
            empty_s[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            full_s[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                         (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
            seg_full_s = (seg_idx_q == SEG_W'(k)) ? full_s[k] : seg_full_s;
        end
    end

    // Head selection: smallest head column, ties resolved toward the lowest queue
    always_comb begin
        head_found_s = 1'b0;
        head_idx_s   = '0;
        head_col_s   = '0;
        head_val_s   = '0;
        take_s       = 1'b0;
        for (int k = 0; k < NQ; k++) begin
            take_s       = !empty_s[k] &&
                           (!head_found_s || (mem_col_q[k][rd_ptr_q[k][AW-1:0]] < head_col_s));
            head_idx_s   = take_s ? QI_W'(k) : head_idx_s;
            head_col_s   = take_s ? mem_col_q[k][rd_ptr_q[k][AW-1:0]] : head_col_s;
            head_val_s   = take_s ? mem_val_q[k][rd_ptr_q[k][AW-1:0]] : head_val_s;
            head_found_s = head_found_s | take_s;
        end
    end

    // Next-state logic for the fill/merge FSM, accumulator and output register
    always_comb begin
        state_d     = state_q;
        seg_idx_d   = seg_idx_q;
        row_d       = row_q;
        acc_valid_d = acc_valid_q;
        acc_val_d   = acc_val_q;
        acc_col_d   = acc_col_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_val_d   = out_val_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        wr_en_s     = 1'b0;
        pop_s       = 1'b0;
        accept_s    = bus.in_valid && (state_q == S_FILL);
        slot_free_s = !out_valid_q || bus.out_ready;

        case (state_q)
            S_FILL: begin
                if (accept_s) begin
                    // Out-of-range segment or full queue: beat is consumed but dropped
                    wr_en_s = (seg_idx_q < SEG_W'(NQ)) && !seg_full_s;
                    err_d   = err_q | !wr_en_s;
                    if (bus.in_row_last) begin
                        seg_idx_d = '0;
                        row_d     = bus.in_row;
                        state_d   = S_MERGE;
                    end else if (bus.in_seg_last) begin
                        seg_idx_d = (seg_idx_q == SEG_W'(NQ)) ? seg_idx_q : seg_idx_q + SEG_W'(1);
                    end else begin
                        seg_idx_d = seg_idx_q;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            S_MERGE: begin
                if (head_found_s) begin
                    if (!acc_valid_q) begin
                        pop_s       = 1'b1;
                        acc_valid_d = 1'b1;
                        acc_val_d   = head_val_s;
                        acc_col_d   = head_col_s;
                    end else if (head_col_s == acc_col_q) begin
                        pop_s     = 1'b1;
                        acc_val_d = acc_val_q + head_val_s;
                    end else if (slot_free_s) begin
                        pop_s       = 1'b1;
                        out_valid_d = 1'b1;
                        out_val_d   = acc_val_q;
                        out_row_d   = row_q;
                        out_col_d   = acc_col_q;
                        out_last_d  = 1'b0;
                        acc_val_d   = head_val_s;
                        acc_col_d   = head_col_s;
                    end else begin
                        pop_s = 1'b0;
                    end
                end else if (acc_valid_q) begin
                    if (slot_free_s) begin
                        out_valid_d = 1'b1;
                        out_val_d   = acc_val_q;
                        out_row_d   = row_q;
                        out_col_d   = acc_col_q;
                        out_last_d  = 1'b1;
                        acc_valid_d = 1'b0;
                        state_d     = S_FILL;
                    end else begin
                        state_d = S_MERGE;
                    end
                end else begin
                    // Every beat of the row was dropped: nothing to emit
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Control state, pointers, accumulator and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            seg_idx_q   <= '0;
            row_q       <= '0;
            acc_valid_q <= 1'b0;
            acc_val_q   <= '0;
            acc_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < NQ; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            seg_idx_q   <= seg_idx_d;
            row_q       <= row_d;
            acc_valid_q <= acc_valid_d;
            acc_val_q   <= acc_val_d;
            acc_col_q   <= acc_col_d;
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            for (int k = 0; k < NQ; k++) begin
                if (wr_en_s && (seg_idx_q == SEG_W'(k))) begin
                    wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                end
                if (pop_s && (head_idx_s == QI_W'(k))) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                end
            end
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        for (int k = 0; k < NQ; k++) begin
            if (wr_en_s && (seg_idx_q == SEG_W'(k))) begin
                mem_val_q[k][wr_ptr_q[k][AW-1:0]] <= bus.in_val;
                mem_col_q[k][wr_ptr_q[k][AW-1:0]] <= bus.in_col;
            end
        end
    end

    assign bus.in_ready     = (state_q == S_FILL);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_val      = out_val_q;
    assign bus.out_row      = out_row_q;
    assign bus.out_col      = out_col_q;
    assign bus.out_row_last = out_last_q;
    assign busy_o           = (state_q != S_FILL);
    assign err_overflow_o   = err_q;
endmodule
